// File: rtl/fp_arb_pkg.sv
// Shared constants, operation codes and FSM state type for the FP add/sub arbiter.
package fp_arb_pkg;
  localparam int FP_W = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/fp_addsub_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module fp_addsub_arbiter_rr #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);
  logic            w_found;
  logic [IDXW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = IDXW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one FP adder/subtractor between NREQ requesters, one operation in flight.
// Optional watchdog in WAIT is enabled by defining FP_ARB_TIMEOUT_EN.
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [FP_W-1:0]      resp_data,
  output logic                 resp_err,
  output logic [FP_W-1:0]      fpu_inA,
  output logic [FP_W-1:0]      fpu_inB,
  output logic                 fpu_op,
  output logic                 fpu_load,
  input  logic [FP_W-1:0]      fpu_out,
  input  logic                 fpu_valid,
  output arb_state_t           o_dbg_state
);
  localparam int IDXW = $clog2(NREQ);

  arb_state_t      r_state, w_state_nxt;
  logic [IDXW-1:0] r_rr_ptr, r_gnt_idx, w_gnt_idx;
  logic [NREQ-1:0] r_gnt_oh, w_gnt_oh;
  logic            w_any_req;
  logic [FP_W-1:0] r_a, r_b, r_result, w_sel_a, w_sel_b;
  logic            r_op, w_sel_op;
  logic            r_fpu_valid_q, w_valid_edge, w_timeout;

  fp_addsub_arbiter_rr #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt_oh),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any_req)
  );

  // Handshake: a request transfers on the posedge where req_valid[i] & req_ready[i];
  // resp_valid is a one-cycle pulse with no backpressure.
  assign req_ready   = (r_state == IDLE) ? w_gnt_oh : '0;
  assign resp_valid  = (r_state == RESP) ? r_gnt_oh : '0;
  assign fpu_load    = (r_state == ISSUE);
  assign fpu_inA     = r_a;
  assign fpu_inB     = r_b;
  assign fpu_op      = r_op;
  assign resp_data   = r_result;
  assign o_dbg_state = r_state;

  assign w_valid_edge = fpu_valid & ~r_fpu_valid_q;

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_a  = req_a[i*FP_W +: FP_W];
        w_sel_b  = req_b[i*FP_W +: FP_W];
        w_sel_op = req_op[i];
      end
    end
  end

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
  logic [CNTW-1:0] r_wait_cnt;
  logic            r_err;

  assign w_timeout = (r_state == WAIT) && !w_valid_edge &&
                     (r_wait_cnt == CNTW'(TIMEOUT_CYC - 1));
  assign resp_err  = (r_state == RESP) && r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == ISSUE) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + CNTW'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_valid_edge || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Deliberately not reset: tracking the FPU level through reset hides a stale valid.
  always_ff @(posedge clk) begin
    r_fpu_valid_q <= fpu_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 1'b0;
      r_result  <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_gnt_idx <= w_gnt_idx;
        r_gnt_oh  <= w_gnt_oh;
        r_a       <= w_sel_a;
        r_b       <= w_sel_b;
        r_op      <= w_sel_op;
      end
      if (r_state == WAIT) begin
        if (w_valid_edge)   r_result <= fpu_out;
        else if (w_timeout) r_result <= FP_QNAN;
      end
      if (r_state == RESP) begin
        r_rr_ptr <= (r_gnt_idx == IDXW'(NREQ - 1)) ? '0 : r_gnt_idx + IDXW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter with a table-driven FPU stand-in (fixed latency).
module tb_fp_addsub_arbiter;
  import fp_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int FPU_LAT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*FP_W-1:0] req_a = '0;
  logic [NREQ*FP_W-1:0] req_b = '0;
  logic [NREQ-1:0]      req_op = '0;
  logic [NREQ-1:0]      req_ready, resp_valid;
  logic [FP_W-1:0]      resp_data, fpu_inA, fpu_inB;
  logic                 resp_err, fpu_op, fpu_load;
  logic [FP_W-1:0]      fpu_out = '0;
  logic                 fpu_valid = 1'b0;
  arb_state_t           dbg_state;

  fp_addsub_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .fpu_inA(fpu_inA), .fpu_inB(fpu_inB), .fpu_op(fpu_op),
    .fpu_load(fpu_load), .fpu_out(fpu_out), .fpu_valid(fpu_valid),
    .o_dbg_state(dbg_state)
  );

  // FPU stand-in: hand-computed IEEE-754 results for the vectors used below
  function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    case ({op, a, b})
      {1'b0, 32'h3FC00000, 32'h3FC00000}: return 32'h40400000; // 1.5+1.5
      {1'b1, 32'hC0400000, 32'h3FC00000}: return 32'hC0900000; // -3-1.5
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
      {1'b0, 32'h00000000, 32'h3FC00000}: return 32'h3FC00000; // 0+1.5
      {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000; // 2-1
      {1'b0, 32'h40400000, 32'h40A00000}: return 32'h41000000; // 3+5
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {1'b0, 32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4
      {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  int          fpu_cnt = 0;
  logic [31:0] fpu_pend = '0;
  bit          fpu_dead = 1'b0;

  always @(posedge clk) begin
    if (fpu_load) begin
      fpu_valid <= 1'b0;
      fpu_cnt   <= FPU_LAT;
      fpu_pend  <= fpu_ref(fpu_inA, fpu_inB, fpu_op);
    end else if (fpu_cnt > 0) begin
      fpu_cnt <= fpu_cnt - 1;
      if (fpu_cnt == 1 && !fpu_dead) begin
        fpu_valid <= 1'b1;
        fpu_out   <= fpu_pend;
      end
    end
  end

  // scoreboard / observation state
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, load_cnt = 0, inflight = 0, max_inflight = 0, bad_onehot = 0;
  int last_load_cyc = 0, last_resp_cyc = 0;
  logic [31:0] last_load_a, last_load_b, last_resp_ina;
  logic        last_load_op;
  logic [NREQ-1:0] hold_mask = '0;
  int          grant_q[$];
  int          resp_idx_q[$];
  logic [31:0] resp_data_q[$];
  logic        resp_err_q[$];
  logic [31:0] exp_q[$];
  logic [NREQ-1:0] s_ready, s_rvalid;
  logic [31:0] s_data, s_ina, s_inb;
  logic        s_err, s_op, s_load;

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i]         = op;
  endtask

  // One clock: sample outputs mid-cycle, then retire accepted requests after the edge
  task automatic step();
    logic [NREQ-1:0] seen;
    @(negedge clk);
    #3;
    cyc++;
    seen = req_ready;
    s_ready = req_ready; s_rvalid = resp_valid; s_data = resp_data; s_err = resp_err;
    s_ina = fpu_inA; s_inb = fpu_inB; s_op = fpu_op; s_load = fpu_load;
    if (req_ready != '0) begin
      grant_q.push_back(oh_idx(req_ready));
      if ($countones(req_ready) != 1) bad_onehot++;
    end
    if (fpu_load) begin
      load_cnt++;
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
      last_load_a = fpu_inA; last_load_b = fpu_inB; last_load_op = fpu_op;
      last_load_cyc = cyc;
    end
    if (resp_valid != '0) begin
      if ($countones(resp_valid) != 1) bad_onehot++;
      resp_idx_q.push_back(oh_idx(resp_valid));
      resp_data_q.push_back(resp_data);
      resp_err_q.push_back(resp_err);
      last_resp_cyc = cyc;
      last_resp_ina = fpu_inA;
      if (inflight > 0) inflight--;
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(seen & ~hold_mask);
  endtask

  task automatic clear_obs();
    grant_q.delete(); resp_idx_q.delete(); resp_data_q.delete();
    resp_err_q.delete(); exp_q.delete();
    max_inflight = 0; bad_onehot = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    inflight = 0;
    clear_obs();
  endtask

  task automatic wait_resps(input int n, input int budget);
    for (int i = 0; i < budget && resp_idx_q.size() < n; i++) step();
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    step();
    n_checks++; if (s_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%h exp=0", s_ready); end
    n_checks++; if (s_rvalid !== '0) begin n_fail++; $display("FAIL reset_resp_valid got=%h exp=0", s_rvalid); end
    n_checks++; if (s_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data got=%h exp=0", s_data); end
    n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", s_err); end
    n_checks++; if ({s_ina, s_inb, s_op, s_load} !== '0) begin
      n_fail++; $display("FAIL reset_fpu_outs got=%h/%h/%b/%b exp=0", s_ina, s_inb, s_op, s_load);
    end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_single();
    int l0;
    clear_obs();
    l0 = load_cnt;
    set_req(0, 32'h3FC00000, 32'h3FC00000, OP_ADD);
    req_valid[0] = 1'b1;
    wait_resps(1, 40);
    n_checks++; if (grant_q.size() !== 1 || grant_q[0] !== 0) begin
      n_fail++; $display("FAIL single_grant got=%0d grants first=%0d exp=1 grant idx 0", grant_q.size(), grant_q[0]);
    end
    n_checks++; if (load_cnt - l0 !== 1) begin n_fail++; $display("FAIL single_loads got=%0d exp=1", load_cnt - l0); end
    n_checks++; if ({last_load_a, last_load_b, last_load_op} !== {32'h3FC00000, 32'h3FC00000, 1'b0}) begin
      n_fail++; $display("FAIL single_fpu_in got=%h %h %b exp=3fc00000 3fc00000 0", last_load_a, last_load_b, last_load_op);
    end
    n_checks++; if (resp_idx_q.size() !== 1 || resp_idx_q[0] !== 0 || resp_data_q[0] !== 32'h40400000) begin
      n_fail++; $display("FAIL single_resp got=n%0d idx%0d %h exp=n1 idx0 40400000", resp_idx_q.size(), resp_idx_q[0], resp_data_q[0]);
    end
    n_checks++; if (last_resp_ina !== 32'h3FC00000) begin
      n_fail++; $display("FAIL single_inA_held got=%h exp=3fc00000", last_resp_ina);
    end
  endtask

  task automatic test_sub();
    clear_obs();
    set_req(2, 32'hC0400000, 32'h3FC00000, OP_SUB);
    req_valid[2] = 1'b1;
    wait_resps(1, 40);
    n_checks++; if (resp_idx_q.size() !== 1 || resp_idx_q[0] !== 2) begin
      n_fail++; $display("FAIL sub_idx got=n%0d idx%0d exp=n1 idx2", resp_idx_q.size(), resp_idx_q[0]);
    end
    n_checks++; if (resp_data_q[0] !== 32'hC0900000) begin
      n_fail++; $display("FAIL sub_data got=%h exp=c0900000", resp_data_q[0]);
    end
    n_checks++; if (resp_err_q[0] !== 1'b0) begin n_fail++; $display("FAIL sub_err got=%b exp=0", resp_err_q[0]); end
    step();
    n_checks++; if (s_data !== 32'hC0900000 || s_rvalid !== '0) begin
      n_fail++; $display("FAIL sub_data_hold got=%h valid=%h exp=c0900000 valid=0", s_data, s_rvalid);
    end
  endtask

  task automatic test_contention();
    int l0;
    apply_reset();
    l0 = load_cnt;
    set_req(0, 32'h3F800000, 32'h3F800000, OP_ADD);
    set_req(1, 32'h00000000, 32'h3FC00000, OP_ADD);
    set_req(2, 32'h40000000, 32'h3F800000, OP_SUB);
    set_req(3, 32'h40400000, 32'h40A00000, OP_ADD);
    exp_q.push_back(32'h40000000); exp_q.push_back(32'h3FC00000);
    exp_q.push_back(32'h3F800000); exp_q.push_back(32'h41000000);
    req_valid = 4'hF;
    wait_resps(4, 120);
    n_checks++; if (resp_idx_q.size() !== 4 || grant_q.size() !== 4) begin
      n_fail++; $display("FAIL cont_count got=%0d resps %0d grants exp=4", resp_idx_q.size(), grant_q.size());
    end
    for (int k = 0; k < resp_idx_q.size() && k < 4; k++) begin
      n_checks++;
      if (grant_q[k] !== k || resp_idx_q[k] !== k || resp_data_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL cont_op%0d got=g%0d r%0d %h exp=g%0d r%0d %h", k, grant_q[k], resp_idx_q[k], resp_data_q[k], k, k, exp_q[k]);
      end
    end
    n_checks++; if (max_inflight !== 1 || load_cnt - l0 !== 4) begin
      n_fail++; $display("FAIL cont_inflight got=max%0d loads%0d exp=max1 loads4", max_inflight, load_cnt - l0);
    end
    n_checks++; if (bad_onehot !== 0) begin n_fail++; $display("FAIL cont_onehot got=%0d exp=0", bad_onehot); end
  endtask

  task automatic test_fairness();
    int exp_g[3];
    logic [31:0] exp_d[3];
    clear_obs();
    exp_g = '{1, 3, 1};
    exp_d = '{32'h40400000, 32'h41000000, 32'h40400000};
    set_req(1, 32'h3F800000, 32'h40000000, OP_ADD);
    set_req(3, 32'h40800000, 32'h40800000, OP_ADD);
    hold_mask = 4'b0010;
    req_valid = 4'b1010;
    for (int i = 0; i < 100 && grant_q.size() < 3; i++) step();
    hold_mask = '0;
    req_valid[1] = 1'b0;
    wait_resps(3, 60);
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (grant_q.size() !== 3 || resp_idx_q.size() !== 3) begin
      n_fail++; $display("FAIL fair_count got=%0d grants %0d resps exp=3", grant_q.size(), resp_idx_q.size());
    end
    for (int k = 0; k < resp_idx_q.size() && k < 3; k++) begin
      n_checks++;
      if (grant_q[k] !== exp_g[k] || resp_idx_q[k] !== exp_g[k] || resp_data_q[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL fair_op%0d got=g%0d r%0d %h exp=%0d %h", k, grant_q[k], resp_idx_q[k], resp_data_q[k], exp_g[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int l0;
    clear_obs();
    l0 = load_cnt;
    set_req(2, 32'h40000000, 32'h40000000, OP_ADD);
    req_valid[2] = 1'b1;
    for (int i = 0; i < 20 && load_cnt == l0; i++) step();
    step();
    step();
    n_checks++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL rstw_in_wait got=%0d exp=%0d", dbg_state, WAIT); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    inflight = 0;
    step();
    n_checks++; if ({s_ready, s_rvalid, s_err, s_load} !== '0) begin
      n_fail++; $display("FAIL rstw_ctrl got=rdy%h rv%h err%b ld%b exp=0", s_ready, s_rvalid, s_err, s_load);
    end
    n_checks++; if ({s_data, s_ina, s_inb, s_op} !== '0) begin
      n_fail++; $display("FAIL rstw_data got=%h %h %h %b exp=0", s_data, s_ina, s_inb, s_op);
    end
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (resp_idx_q.size() !== 0) begin
      n_fail++; $display("FAIL rstw_no_resp got=%0d resps exp=0", resp_idx_q.size());
    end
    clear_obs();
    set_req(1, 32'h3F800000, 32'h40000000, OP_ADD);
    set_req(3, 32'h40800000, 32'h40800000, OP_ADD);
    req_valid = 4'b1010;
    wait_resps(2, 80);
    n_checks++; if (resp_idx_q.size() !== 2 || resp_idx_q[0] !== 1 || resp_idx_q[1] !== 3) begin
      n_fail++; $display("FAIL rstw_ptr_order got=n%0d %0d,%0d exp=n2 1,3", resp_idx_q.size(), resp_idx_q[0], resp_idx_q[1]);
    end
    n_checks++; if (resp_data_q[0] !== 32'h40400000 || resp_data_q[1] !== 32'h41000000) begin
      n_fail++; $display("FAIL rstw_data_after got=%h,%h exp=40400000,41000000", resp_data_q[0], resp_data_q[1]);
    end
  endtask

`ifdef FP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    clear_obs();
    fpu_dead = 1'b1;
    set_req(0, 32'h3FC00000, 32'h3FC00000, OP_ADD);
    req_valid[0] = 1'b1;
    wait_resps(1, 150);
    fpu_dead = 1'b0;
    n_checks++; if (resp_idx_q.size() !== 1 || resp_idx_q[0] !== 0 || resp_err_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL tmo_resp got=n%0d idx%0d err%b exp=n1 idx0 err1", resp_idx_q.size(), resp_idx_q[0], resp_err_q[0]);
    end
    n_checks++; if (resp_data_q[0] !== 32'h7FC00000) begin
      n_fail++; $display("FAIL tmo_data got=%h exp=7fc00000", resp_data_q[0]);
    end
    n_checks++; if (last_resp_cyc - last_load_cyc !== 65) begin
      n_fail++; $display("FAIL tmo_latency got=%0d exp=65", last_resp_cyc - last_load_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_sub();
    test_contention();
    test_fairness();
    test_reset_mid_wait();
`ifdef FP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
